// File: rtl/keypad_pkg.sv
// Shared types, key map and column-drive helper for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, CAND, PRESSED} kp_state_t;

    typedef enum {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_res_t;

    // Indexed [column][row]; row 0 first within each column.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows; resets to idle (all ones).
module keypad_row_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-level debounce and a one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to enable typematic repeat while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_BITS      = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_SCANS + 1);

    // Rows need two dwell cycles to pass the synchronizer after a column change.
    if (SCAN_BITS < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scanner: SCAN_BITS>=2, DEBOUNCE_SCANS>=1, REPEAT_SCANS>=1 required");
    end

    logic [3:0]           row_s;
    logic [SCAN_BITS-1:0] dwell;
    logic [1:0]           col_idx;
    logic [1:0]           acc_hits;
    logic [3:0]           acc_code;

    kp_state_t            state;
    logic [3:0]           cand;
    logic [DB_W-1:0]      stable;
    logic [DB_W-1:0]      rel;

    logic [3:0]           col_low;
    logic [2:0]           col_hits;
    logic [3:0]           col_code;
    logic [2:0]           tot_hits;
    logic [3:0]           scan_code;
    scan_res_t            scan_res;
    logic                 sample;
    logic                 scan_end;
    logic                 single;
    logic [DB_W-1:0]      stable_nxt;
    logic                 accept;

    keypad_row_sync #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row),
        .q     (row_s)
    );

    // Classify the current column merged with the scan accumulated so far.
    always_comb begin
        col_low  = ~row_s;
        col_hits = 3'd0;
        col_code = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            col_hits = col_hits + 3'(col_low[r]);
            if (col_low[r]) begin
                col_code = KEY_MAP[col_idx][2'(r)];
            end
        end
        tot_hits  = 3'(acc_hits) + col_hits;
        scan_code = (col_hits != 3'd0) ? col_code : acc_code;
        if (tot_hits == 3'd0) begin
            scan_res = SCAN_NONE;
        end else if (tot_hits == 3'd1) begin
            scan_res = SCAN_SINGLE;
        end else begin
            scan_res = SCAN_MULTI;
        end
        sample     = (dwell == '1);
        scan_end   = sample && (col_idx == 2'd3);
        single     = (scan_res == SCAN_SINGLE);
        stable_nxt = (state == CAND && scan_code == cand) ? stable + DB_W'(1) : DB_W'(1);
        accept     = single && (state != PRESSED) && (stable_nxt == DB_W'(DEBOUNCE_SCANS));
    end

    // Column dwell timing and per-scan hit accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell    <= '0;
            col_idx  <= 2'd0;
            col      <= 4'b1110;
            acc_hits <= 2'd0;
            acc_code <= 4'h0;
        end else begin
            dwell <= dwell + SCAN_BITS'(1);
            if (sample) begin
                col_idx <= col_idx + 2'd1;
                col     <= col_drive(col_idx + 2'd1);
                if (scan_end) begin
                    acc_hits <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_hits <= (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
                    acc_code <= scan_code;
                end
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RP_W = $clog2(REPEAT_SCANS + 1);
    logic [RP_W-1:0] rep;
`endif

    // Debounce FSM: advances only on scan-end cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 4'h0;
            stable    <= '0;
            rel       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep       <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE, CAND: begin
                        if (!single) begin
                            state  <= IDLE;
                            stable <= '0;
                        end else if (accept) begin
                            state     <= PRESSED;
                            key_code  <= scan_code;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            stable    <= '0;
                            rel       <= '0;
`ifdef KEYPAD_REPEAT_EN
                            rep       <= '0;
`endif
                        end else begin
                            state  <= CAND;
                            cand   <= scan_code;
                            stable <= stable_nxt;
                        end
                    end
                    PRESSED: begin
                        if (single) begin
                            rel <= '0;
                        end else if (rel + DB_W'(1) == DB_W'(DEBOUNCE_SCANS)) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                            rel      <= '0;
                        end else begin
                            rel <= rel + DB_W'(1);
                        end
`ifdef KEYPAD_REPEAT_EN
                        if (single && scan_code == key_code) begin
                            if (rep + RP_W'(1) == RP_W'(REPEAT_SCANS)) begin
                                key_valid <= 1'b1;
                                rep       <= '0;
                            end else begin
                                rep <= rep + RP_W'(1);
                            end
                        end else begin
                            rep <= '0;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: electrical keypad model plus a scan-history reference model.
module tb_keypad_scanner;

    localparam int unsigned SB  = 2;
    localparam int unsigned DEB = 4;
    localparam int unsigned REP = 8;
    localparam int SCAN_CYC = 4 * (1 << SB);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int n;
    int errors = 0;
    int checks = 0;
    int strobes = 0;
    bit prev_valid = 1'b0;
    int hist[$];
    bit m_pressed = 1'b0;
    logic [3:0] m_code = 4'h0;
    int m_rep = 0;
    int map_v[16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    always #5 clk = ~clk;

    // Key (c,r) down pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
    end

    keypad_scanner #(.SCAN_BITS(SB), .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    function automatic logic [15:0] kb(input int c, input int r);
        return 16'(1) << (c * 4 + r);
    endfunction

    function automatic int classify(input logic [15:0] k);
        if ($countones(k) != 1) return -1;
        for (int i = 0; i < 16; i++)
            if (k[i]) return map_v[i];
        return -1;
    endfunction

    // True when the last DEB scans were all SINGLE(v) (or all key-less when none_mode).
    function automatic bit last_all(input int v, input bit none_mode);
        if (hist.size() < DEB) return 1'b0;
        for (int j = hist.size() - DEB; j < hist.size(); j++) begin
            if (none_mode ? (hist[j] >= 0) : (hist[j] != v)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic check_cycle();
        bit exp_v;
        logic [3:0] exp_col;
        int s;
        exp_v = 1'b0;
        if (reset) begin
            hist.delete();
            m_pressed = 1'b0;
            m_code    = 4'h0;
            m_rep     = 0;
            exp_col   = 4'b1110;
        end else begin
            if (n > 0 && n % SCAN_CYC == 0) begin
                s = classify(keys);
                hist.push_back(s);
                if (!m_pressed) begin
                    if (s >= 0 && last_all(s, 1'b0)) begin
                        m_pressed = 1'b1;
                        m_code    = s[3:0];
                        exp_v     = 1'b1;
                        m_rep     = 0;
                        hist.delete();
                    end
                end else if (last_all(0, 1'b1)) begin
                    m_pressed = 1'b0;
                    hist.delete();
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (s == int'(m_code)) m_rep++;
                    else m_rep = 0;
                    if (m_rep == int'(REP)) begin
                        exp_v = 1'b1;
                        m_rep = 0;
                    end
`endif
                end
            end
            exp_col = ~(4'b0001 << ((n / (1 << SB)) % 4));
        end
        check("col", col, exp_col);
        check("key_valid", key_valid, exp_v);
        check("key_held", key_held, m_pressed);
        check("key_code", key_code, m_code);
        check("valid_back_to_back", key_valid && prev_valid, 0);
        if (key_valid) strobes++;
        prev_valid = key_valid;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run_scans(input logic [15:0] k, input int cnt);
        repeat (cnt) begin
            keys = k;
            repeat (SCAN_CYC) cycle();
        end
    endtask

    task automatic do_reset(input logic [15:0] k);
        reset = 1'b1;
        keys  = k;
        repeat (3) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int s0;
        logic [15:0] rk;
        logic [3:0] lit;

        do_reset('0);
        check("rst_col", col, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_code", key_code, 0);

        for (int i = 0; i < SCAN_CYC; i++) begin
            cycle();
            lit = (i < 3) ? 4'b1110 : (i < 7) ? 4'b1101 : (i < 11) ? 4'b1011 :
                  (i < 15) ? 4'b0111 : 4'b1110;
            check("col_seq", col, lit);
        end

        // Clean press of '6' then release.
        s0 = strobes;
        run_scans(kb(2, 1), 10);
        check("press6_strobes", strobes - s0, 1);
        check("press6_code", key_code, 4'h6);
        check("press6_held", key_held, 1);
        run_scans('0, 4);
        check("release6_held", key_held, 0);

        // Bouncing '1'.
        s0 = strobes;
        for (int i = 0; i < 12; i++) run_scans((i % 2 == 0) ? kb(0, 0) : 16'h0, 1);
        check("bounce_strobes", strobes - s0, 0);
        check("bounce_held", key_held, 0);
        run_scans('0, 2);

        // '1' and '2' together, then '2' released.
        s0 = strobes;
        run_scans(kb(0, 0) | kb(1, 0), 8);
        check("multi_strobes", strobes - s0, 0);
        run_scans(kb(0, 0), 3);
        check("multi_rel_early", strobes - s0, 0);
        run_scans(kb(0, 0), 1);
        check("multi_rel_strobe", strobes - s0, 1);
        check("multi_rel_code", key_code, 4'h1);
        run_scans('0, 4);

        // Typematic repeat on '5': accept at scan 4, repeats at 12 and 20.
        s0 = strobes;
        run_scans(kb(1, 1), 22);
`ifdef KEYPAD_REPEAT_EN
        check("repeat5_strobes", strobes - s0, 3);
`else
        check("repeat5_strobes", strobes - s0, 1);
`endif
        check("repeat5_code", key_code, 4'h5);
        run_scans('0, 4);

        // No rollover, then reset with 'A' still held.
        run_scans(kb(3, 0), 5);
        s0 = strobes;
        run_scans(kb(3, 0) | kb(3, 1), 3);
        check("rollover_strobes", strobes - s0, 0);
        check("rollover_held", key_held, 1);
        check("rollover_code", key_code, 4'hA);
        do_reset(kb(3, 0));
        check("midrst_held", key_held, 0);
        check("midrst_code", key_code, 0);
        s0 = strobes;
        run_scans(kb(3, 0), 3);
        check("rearm_early", strobes - s0, 0);
        run_scans(kb(3, 0), 1);
        check("rearm_strobe", strobes - s0, 1);
        check("rearm_code", key_code, 4'hA);
        run_scans('0, 4);

        // Randomized key activity, with a reset pulse mid-scan part way through.
        for (int i = 0; i < 40; i++) begin
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick < 4)      rk = '0;
            else if (pick < 8) rk = kb(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else               rk = kb(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))) |
                                    kb(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            run_scans(rk, int'($urandom_range(1, 7)));
            if (i == 20) begin
                repeat (7) cycle();
                do_reset(rk);
            end
        end
        run_scans('0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
